// File: rtl/multi_chan_timer.sv
// N-channel programmable down-counting timer with a shared prescaler,
// per-channel reload, one-shot/auto-reload modes, sticky flags and a masked irq.
module multi_chan_timer #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned PRESC_W  = 8,
  parameter int unsigned RST_VLU  = 0
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic [PRESC_W-1:0]          presc_div,
  input  logic [CHANNELS-1:0]         load,
  input  logic [CHANNELS*WIDTH-1:0]   load_val,
  input  logic [CHANNELS-1:0]         en,
  input  logic [CHANNELS-1:0]         auto_rld,
  input  logic [CHANNELS-1:0]         irq_en,
  input  logic [CHANNELS-1:0]         flag_clr,
  output logic [CHANNELS*WIDTH-1:0]   count,
  output logic [CHANNELS-1:0]         armed,
  output logic [CHANNELS-1:0]         tc_pulse,
  output logic [CHANNELS-1:0]         flag,
  output logic                        irq
);

  localparam logic [WIDTH-1:0] RST_CNT = WIDTH'(RST_VLU);

  logic [PRESC_W-1:0]              presc_cnt;
  logic [PRESC_W-1:0]              presc_nxt;
  logic                            tick;

  logic [CHANNELS-1:0][WIDTH-1:0]  cnt_q;
  logic [CHANNELS-1:0][WIDTH-1:0]  cnt_d;
  logic [CHANNELS-1:0][WIDTH-1:0]  rld_q;
  logic [CHANNELS-1:0][WIDTH-1:0]  rld_d;
  logic [CHANNELS-1:0]             armed_q;
  logic [CHANNELS-1:0]             armed_d;
  logic [CHANNELS-1:0]             tc_q;
  logic [CHANNELS-1:0]             tc_d;
  logic [CHANNELS-1:0]             flag_q;
  logic [CHANNELS-1:0]             flag_d;

  // Shared free-running prescaler; reset to 0 so the first tick follows release.
  always_comb begin
    tick      = (presc_cnt == '0);
    presc_nxt = tick ? presc_div : presc_cnt - PRESC_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      presc_cnt <= '0;
    end else begin
      presc_cnt <= presc_nxt;
    end
  end

  // Per-channel next state: load beats an active tick; a tick on 0 is an expire.
  always_comb begin
    cnt_d   = cnt_q;
    rld_d   = rld_q;
    armed_d = armed_q;
    tc_d    = '0;
    flag_d  = flag_q;
    for (int i = 0; i < CHANNELS; i++) begin
      if (load[i]) begin
        rld_d[i]   = load_val[i*WIDTH +: WIDTH];
        cnt_d[i]   = load_val[i*WIDTH +: WIDTH];
        armed_d[i] = 1'b1;
      end else if (tick && en[i] && armed_q[i]) begin
        if (cnt_q[i] != '0) begin
          cnt_d[i] = cnt_q[i] - WIDTH'(1);
        end else begin
          tc_d[i] = 1'b1;
          if (auto_rld[i]) begin
            cnt_d[i] = rld_q[i];
          end else begin
            armed_d[i] = 1'b0;
          end
        end
      end
      flag_d[i] = tc_d[i] | (flag_q[i] & ~flag_clr[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i] <= RST_CNT;
        rld_q[i] <= RST_CNT;
      end
      armed_q <= '0;
      tc_q    <= '0;
      flag_q  <= '0;
    end else begin
      cnt_q   <= cnt_d;
      rld_q   <= rld_d;
      armed_q <= armed_d;
      tc_q    <= tc_d;
      flag_q  <= flag_d;
    end
  end

  assign count    = cnt_q;
  assign armed    = armed_q;
  assign tc_pulse = tc_q;
  assign flag     = flag_q;
  assign irq      = |(flag_q & irq_en);

endmodule

// File: tb/tb_multi_chan_timer.sv
// Self-checking bench for multi_chan_timer: directed vectors plus random stimulus
// against a cycle-level reference model built from the timer rules.
module tb_multi_chan_timer;

  localparam int unsigned W  = 32;
  localparam int unsigned N  = 4;
  localparam int unsigned PW = 8;

  logic             clk = 1'b0;
  logic             rstn;
  logic [PW-1:0]    presc_div;
  logic [N-1:0]     load;
  logic [N*W-1:0]   load_val;
  logic [N-1:0]     en;
  logic [N-1:0]     auto_rld;
  logic [N-1:0]     irq_en;
  logic [N-1:0]     flag_clr;
  logic [N*W-1:0]   count;
  logic [N-1:0]     armed;
  logic [N-1:0]     tc_pulse;
  logic [N-1:0]     flag;
  logic             irq;

  multi_chan_timer #(.WIDTH(W), .CHANNELS(N), .PRESC_W(PW), .RST_VLU(0)) dut (
    .clk(clk), .rstn(rstn), .presc_div(presc_div), .load(load), .load_val(load_val),
    .en(en), .auto_rld(auto_rld), .irq_en(irq_en), .flag_clr(flag_clr),
    .count(count), .armed(armed), .tc_pulse(tc_pulse), .flag(flag), .irq(irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: registered state after each edge, plus the edge index
  // (since reset) at which the next prescaler tick is due.
  logic [W-1:0] m_cnt [N];
  logic [W-1:0] m_rld [N];
  logic [N-1:0] m_armed, m_tc, m_flag;
  int           m_e, m_next;

  typedef struct {
    logic         ld;
    logic [W-1:0] val;
    logic [W-1:0] exp_cnt;
    logic         exp_tc;
  } vec_t;
  vec_t tbl [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] cnt_of(input int i);
    return count[i*W +: W];
  endfunction

  task automatic set_lv(input int i, input logic [W-1:0] v);
    load_val[i*W +: W] = v;
  endtask

  task automatic model_edge();
    bit tk;
    if (!rstn) begin
      for (int i = 0; i < N; i++) begin
        m_cnt[i] = '0;
        m_rld[i] = '0;
      end
      m_armed = '0; m_tc = '0; m_flag = '0;
      m_e = 0; m_next = 0;
    end else begin
      tk = (m_e == m_next);
      if (tk) m_next = m_e + int'(presc_div) + 1;
      m_e++;
      for (int i = 0; i < N; i++) begin
        m_tc[i] = 1'b0;
        if (load[i]) begin
          m_rld[i] = load_val[i*W +: W];
          m_cnt[i] = load_val[i*W +: W];
          m_armed[i] = 1'b1;
        end else if (tk && en[i] && m_armed[i]) begin
          if (m_cnt[i] != 0) m_cnt[i] = m_cnt[i] - 1;
          else begin
            m_tc[i] = 1'b1;
            if (auto_rld[i]) m_cnt[i] = m_rld[i];
            else m_armed[i] = 1'b0;
          end
        end
        m_flag[i] = m_tc[i] | (m_flag[i] & ~flag_clr[i]);
      end
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      chk($sformatf("model_count%0d", i), cnt_of(i), m_cnt[i]);
      chk($sformatf("model_armed%0d", i), 32'(armed[i]), 32'(m_armed[i]));
      chk($sformatf("model_tc%0d", i), 32'(tc_pulse[i]), 32'(m_tc[i]));
      chk($sformatf("model_flag%0d", i), 32'(flag[i]), 32'(m_flag[i]));
    end
    chk("model_irq", 32'(irq), 32'(|(m_flag & irq_en)));
  endtask

  // Advance until the coming edge carries a prescaler tick (bounded).
  task automatic wait_tick(input string name);
    int n = 0;
    while (m_e != m_next && n < 100) begin
      step();
      n++;
    end
    checks++;
    if (n >= 100) begin
      errors++;
      $display("FAIL %s: tick wait timed out after %0d cycles", name, n);
    end
  endtask

  initial begin
    tbl[0] = '{1'b1, 32'd3, 32'd3, 1'b0};
    tbl[1] = '{1'b0, 32'd0, 32'd2, 1'b0};
    tbl[2] = '{1'b0, 32'd0, 32'd1, 1'b0};
    tbl[3] = '{1'b0, 32'd0, 32'd0, 1'b0};
    tbl[4] = '{1'b0, 32'd0, 32'd3, 1'b1};
    tbl[5] = '{1'b0, 32'd0, 32'd2, 1'b0};
    tbl[6] = '{1'b0, 32'd0, 32'd1, 1'b0};
    tbl[7] = '{1'b0, 32'd0, 32'd0, 1'b0};
    tbl[8] = '{1'b0, 32'd0, 32'd3, 1'b1};
    tbl[9] = '{1'b0, 32'd0, 32'd2, 1'b0};

    rstn = 1'b0; presc_div = '0; load = '0; load_val = '0; en = '0;
    auto_rld = '0; irq_en = '0; flag_clr = '0;

    // 1: idle after reset
    repeat (3) step();
    rstn = 1'b1;
    for (int i = 0; i < N; i++) chk("reset_count", cnt_of(i), 32'd0);
    chk("reset_armed", 32'(armed), 32'd0);
    chk("reset_tc", 32'(tc_pulse), 32'd0);
    chk("reset_flag", 32'(flag), 32'd0);
    chk("reset_irq", 32'(irq), 32'd0);

    // 2: ch0 auto-reload of 3 with a tick every cycle
    en[0] = 1'b1; auto_rld[0] = 1'b1;
    for (int r = 0; r < 10; r++) begin
      load[0] = tbl[r].ld;
      set_lv(0, tbl[r].val);
      step();
      chk($sformatf("t2_count_row%0d", r), cnt_of(0), tbl[r].exp_cnt);
      chk($sformatf("t2_tc_row%0d", r), 32'(tc_pulse[0]), 32'(tbl[r].exp_tc));
    end
    load[0] = 1'b0;

    // 3: ch1 one-shot of 2
    begin
      int pulses = 0;
      load[1] = 1'b1; set_lv(1, 32'd2); en[1] = 1'b1; auto_rld[1] = 1'b0;
      step();
      load[1] = 1'b0;
      chk("t3_load_count", cnt_of(1), 32'd2);
      step(); chk("t3_count1", cnt_of(1), 32'd1);
      step(); chk("t3_count0", cnt_of(1), 32'd0);
      chk("t3_armed_before", 32'(armed[1]), 32'd1);
      step();
      chk("t3_expire_tc", 32'(tc_pulse[1]), 32'd1);
      chk("t3_expire_armed", 32'(armed[1]), 32'd0);
      chk("t3_expire_flag", 32'(flag[1]), 32'd1);
      repeat (20) begin
        step();
        if (tc_pulse[1]) pulses++;
      end
      chk("t3_no_more_pulses", 32'(pulses), 32'd0);
      chk("t3_hold_count", cnt_of(1), 32'd0);
      chk("t3_hold_armed", 32'(armed[1]), 32'd0);
    end

    // 4: prescaler of 4, ch2 auto-reload of 1, then a 10-cycle freeze
    presc_div = 8'd3;
    load[2] = 1'b1; set_lv(2, 32'd1); en[2] = 1'b1; auto_rld[2] = 1'b1;
    step();
    load[2] = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      step();
      chk($sformatf("t4_count_k%0d", k), cnt_of(2), ((k / 4) % 2 == 1) ? 32'd0 : 32'd1);
      chk($sformatf("t4_tc_k%0d", k), 32'(tc_pulse[2]), 32'((k % 8) == 0));
    end
    en[2] = 1'b0;
    for (int k = 17; k <= 26; k++) begin
      step();
      chk($sformatf("t4_freeze_k%0d", k), cnt_of(2), 32'd1);
      chk($sformatf("t4_freeze_tc_k%0d", k), 32'(tc_pulse[2]), 32'd0);
    end
    en[2] = 1'b1;
    step(); chk("t4_resume_k27", cnt_of(2), 32'd1);
    step(); chk("t4_resume_k28", cnt_of(2), 32'd0);

    // 5: load colliding with an expiring tick, set/clear collision, masking
    load[3] = 1'b1; set_lv(3, 32'd0); en[3] = 1'b1; auto_rld[3] = 1'b0;
    step();
    load[3] = 1'b0;
    wait_tick("t5_wait1");
    load[3] = 1'b1; set_lv(3, 32'd5);
    step();
    load[3] = 1'b0;
    chk("t5_load_wins_count", cnt_of(3), 32'd5);
    chk("t5_load_wins_tc", 32'(tc_pulse[3]), 32'd0);
    chk("t5_load_wins_flag", 32'(flag[3]), 32'd0);
    chk("t5_load_wins_armed", 32'(armed[3]), 32'd1);
    load[3] = 1'b1; set_lv(3, 32'd0);
    step();
    load[3] = 1'b0;
    wait_tick("t5_wait2");
    flag_clr[3] = 1'b1;
    step();
    flag_clr[3] = 1'b0;
    chk("t5_set_wins_tc", 32'(tc_pulse[3]), 32'd1);
    chk("t5_set_wins_flag", 32'(flag[3]), 32'd1);
    chk("t5_masked_irq", 32'(irq), 32'd0);
    irq_en = 4'b1000;
    #1;
    chk("t5_unmasked_irq", 32'(irq), 32'd1);
    flag_clr[3] = 1'b1;
    step();
    flag_clr[3] = 1'b0;
    chk("t5_cleared_flag", 32'(flag[3]), 32'd0);
    chk("t5_cleared_irq", 32'(irq), 32'd0);

    // 6: one-cycle reset mid-count, then first tick right after release
    presc_div = 8'd0; en = '1; auto_rld = '1; load = '1;
    for (int i = 0; i < N; i++) set_lv(i, 32'd10);
    step();
    load = '0;
    repeat (3) step();
    rstn = 1'b0;
    step();
    for (int i = 0; i < N; i++) chk($sformatf("t6_reset_count%0d", i), cnt_of(i), 32'd0);
    chk("t6_reset_armed", 32'(armed), 32'd0);
    chk("t6_reset_tc", 32'(tc_pulse), 32'd0);
    chk("t6_reset_flag", 32'(flag), 32'd0);
    chk("t6_reset_irq", 32'(irq), 32'd0);
    rstn = 1'b1; presc_div = 8'd2; load = 4'b0001; set_lv(0, 32'd0); auto_rld[0] = 1'b0;
    step();
    load = '0;
    for (int k = 1; k <= 4; k++) begin
      step();
      chk($sformatf("t6_phase_tc_k%0d", k), 32'(tc_pulse[0]), 32'(k == 3));
      chk($sformatf("t6_phase_armed_k%0d", k), 32'(armed[0]), 32'(k < 3));
    end

    // Random stimulus against the model
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        load[i]     = ($urandom_range(0, 15) == 0);
        set_lv(i, W'($urandom_range(0, 7)));
        en[i]       = ($urandom_range(0, 7) != 0);
        flag_clr[i] = ($urandom_range(0, 7) == 0);
        if ($urandom_range(0, 31) == 0) auto_rld[i] = ~auto_rld[i];
      end
      if ($urandom_range(0, 63) == 0) presc_div = PW'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) irq_en = N'($urandom);
      rstn = ($urandom_range(0, 499) != 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
